fifo_rd_drain: RTL and testbench

- Read-side consumer for the team's async FIFO. Sits in the rclk domain on the FIFO read port (rdata, rempty, rinc).
- The FIFO read port is first-word-fall-through: rdata is valid whenever rempty=0, and rinc pops the current word.
- The block pops words in programmable bursts separated by idle gaps, buffers them in a 2-entry output stage, and presents them on a valid/ready stream.
- Also maintains a popped-word count and a running XOR checksum.

---
 rtl/fifo_drain_pkg.sv | 12 +
 rtl/rd_skid_buf.sv | 53 +++++
 rtl/fifo_rd_drain.sv | 97 +++++++++
 tb/tb_fifo_rd_drain.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_pkg.sv
// rtl/fifo_drain_pkg.sv - shared types and constants for the FIFO read-side drain
package fifo_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } drain_state_t;

  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/rd_skid_buf.sv
// rtl/rd_skid_buf.sv - 2-entry ordered output buffer between FIFO pops and the stream
module rd_skid_buf
  import fifo_drain_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             push,
  input  logic [DSIZE-1:0] push_data,
  input  logic             pop,
  output logic [DSIZE-1:0] head_data,
  output logic [1:0]       occ
);

  logic [DSIZE-1:0] head_q;
  logic [DSIZE-1:0] tail_q;
  logic [1:0]       occ_q;

  assign head_data = head_q;
  assign occ       = occ_q;

  // Callers never push when full nor pop when empty, so only legal cases are decoded.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) head_q <= push_data;
          else               tail_q <= push_data;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          occ_q  <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            head_q <= push_data;
          end else begin
            head_q <= tail_q;
            tail_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_drain.sv
// rtl/fifo_rd_drain.sv - bursty FIFO read-side consumer with stream output, count and XOR checksum
module fifo_rd_drain
  import fifo_drain_pkg::*;
#(
  parameter int DSIZE  = 8,
  parameter int BLEN_W = 5,
  parameter int GAP_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              rclk,
  input  logic              rrst,
  input  logic              en,
  input  logic [BLEN_W-1:0] burst_len,
  input  logic [GAP_W-1:0]  gap_len,
  input  logic [DSIZE-1:0]  rdata,
  input  logic              rempty,
  output logic              rinc,
  output logic [DSIZE-1:0]  m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  rd_count,
  output logic [DSIZE-1:0]  xsum,
  output logic              busy
);

  drain_state_t      state, state_nxt;
  logic [BLEN_W-1:0] blen_q;
  logic [BLEN_W-1:0] bcnt;
  logic [GAP_W-1:0]  gap_q;
  logic [GAP_W-1:0]  gcnt;
  logic [1:0]        occ;
  logic              burst_done;

  rd_skid_buf #(.DSIZE(DSIZE)) u_buf (
    .rclk      (rclk),
    .rrst      (rrst),
    .push      (rinc),
    .push_data (rdata),
    .pop       (m_valid & m_ready),
    .head_data (m_data),
    .occ       (occ)
  );

  assign m_valid = (occ != 2'd0);
  assign busy    = (state != IDLE) | m_valid;

  // Widened compare so burst_len at its maximum still terminates the burst.
  assign burst_done = (blen_q != '0) &&
                      ((BLEN_W+1)'(bcnt) + (BLEN_W+1)'(1) == (BLEN_W+1)'(blen_q));

  always_comb begin
    rinc      = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (en && !rempty) state_nxt = BURST;
      end
      BURST: begin
        rinc = en & ~rempty & (occ < 2'(BUF_DEPTH));
        if (!en)                     state_nxt = IDLE;
        else if (rinc && burst_done) state_nxt = (gap_q == '0) ? IDLE : GAP;
      end
      GAP: begin
        if (!en || gcnt == GAP_W'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state    <= IDLE;
      blen_q   <= '0;
      gap_q    <= '0;
      bcnt     <= '0;
      gcnt     <= '0;
      rd_count <= '0;
      xsum     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == BURST) begin
        blen_q <= burst_len;
        gap_q  <= gap_len;
        bcnt   <= '0;
      end else if (rinc) begin
        bcnt <= bcnt + BLEN_W'(1);
      end
      if (rinc) begin
        rd_count <= rd_count + CNT_W'(1);
        xsum     <= xsum ^ rdata;
      end
      if (state == BURST && state_nxt == GAP) gcnt <= gap_q;
      else if (state == GAP)                  gcnt <= gcnt - GAP_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb/tb_fifo_rd_drain.sv - self-checking bench for fifo_rd_drain against a queue-based reference
module tb_fifo_rd_drain;

  localparam int DSIZE  = 8;
  localparam int BLEN_W = 5;
  localparam int GAP_W  = 4;
  localparam int CNT_W  = 4;

  logic              rclk = 1'b0;
  logic              rrst;
  logic              en;
  logic [BLEN_W-1:0] burst_len;
  logic [GAP_W-1:0]  gap_len;
  logic [DSIZE-1:0]  rdata;
  logic              rempty;
  logic              rinc;
  logic [DSIZE-1:0]  m_data;
  logic              m_valid;
  logic              m_ready;
  logic [CNT_W-1:0]  rd_count;
  logic [DSIZE-1:0]  xsum;
  logic              busy;

  fifo_rd_drain #(
    .DSIZE(DSIZE), .BLEN_W(BLEN_W), .GAP_W(GAP_W), .CNT_W(CNT_W)
  ) dut (
    .rclk(rclk), .rrst(rrst), .en(en), .burst_len(burst_len), .gap_len(gap_len),
    .rdata(rdata), .rempty(rempty), .rinc(rinc), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .rd_count(rd_count), .xsum(xsum), .busy(busy)
  );

  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;

  logic [7:0] fq[$];
  logic [7:0] expq[$];
  bit         rinc_log[$];
  bit         vlog[$];
  logic [7:0] dlog[$];
  int         cnt  = 0;
  int         npop = 0;
  int         nhs  = 0;
  logic [7:0] xs   = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive FIFO head, check outputs against the model, then advance the model.
  task automatic cyc();
    bit p, h;
    logic [7:0] w;
    rempty = (fq.size() == 0);
    rdata  = rempty ? 8'h00 : fq[0];
    #1;
    chk("m_valid_occ", m_valid, expq.size() != 0);
    if (m_valid && expq.size() != 0) chk("m_data_head", m_data, expq[0]);
    if (m_valid) chk("busy_when_valid", busy, 1);
    chk("rd_count", rd_count, cnt % (1 << CNT_W));
    chk("xsum", xsum, xs);
    if (rinc) chk("rinc_gate", {en, rempty, expq.size() < 2}, 3'b101);
    rinc_log.push_back(rinc);
    vlog.push_back(m_valid);
    dlog.push_back(m_data);
    p = rinc;
    h = m_valid & m_ready;
    @(posedge rclk);
    if (rrst) begin
      expq.delete();
      cnt = 0;
      xs  = 8'h00;
    end else begin
      if (h && expq.size() != 0) begin
        void'(expq.pop_front());
        nhs++;
      end
      if (p) begin
        w = fq.pop_front();
        expq.push_back(w);
        cnt++;
        npop++;
        xs = xs ^ w;
      end
    end
    @(negedge rclk);
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) fq.push_back(8'($urandom));
  endtask

  task automatic run_pops(input string tag, input int target, input int bound);
    int b;
    b = npop;
    for (int i = 0; i < bound && npop - b < target; i++) cyc();
    chk(tag, npop - b, target);
  endtask

  task automatic idle_cycles(input int n);
    en = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Expected pop pattern: bursts of burst_len words (last one shorter), gap_len+1 low cycles between.
  task automatic check_runs(input string tag, input int n, input int bl, input int gl);
    int eh[$];
    int hr[$];
    int lr[$];
    int rem, run, low;
    bit seen;
    rem = n; run = 0; low = 0; seen = 0;
    while (rem > 0) begin
      eh.push_back((bl == 0 || bl > rem) ? rem : bl);
      rem -= eh[$];
    end
    foreach (rinc_log[i]) begin
      if (rinc_log[i]) begin
        if (seen && run == 0) lr.push_back(low);
        run++; low = 0; seen = 1;
      end else begin
        if (run > 0) begin hr.push_back(run); run = 0; end
        low++;
      end
    end
    if (run > 0) hr.push_back(run);
    chk({tag, "_nbursts"}, hr.size(), eh.size());
    for (int i = 0; i < hr.size() && i < eh.size(); i++) chk({tag, "_burst_len"}, hr[i], eh[i]);
    foreach (lr[i]) chk({tag, "_gap_cycles"}, lr[i], gl + 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int f, bad, b;
    rrst = 1'b1; en = 1'b0; burst_len = '0; gap_len = '0;
    rdata = '0; rempty = 1'b1; m_ready = 1'b0;
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    rrst = 1'b0;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_rinc", rinc, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_xsum", xsum, 0);
    chk("rst_busy", busy, 0);

    // Unlimited burst of three known words
    fq = '{8'h11, 8'h22, 8'h33};
    en = 1'b1; burst_len = 0; gap_len = 0; m_ready = 1'b1;
    rinc_log.delete(); vlog.delete(); dlog.delete();
    repeat (8) cyc();
    check_runs("t1", 3, 0, 0);
    f = -1;
    foreach (rinc_log[i]) if (rinc_log[i] && f < 0) f = i;
    chk("t1_first_rinc_cycle", f, 1);
    if (f >= 0) begin
      chk("t1_valid0", vlog[f+1], 1); chk("t1_data0", dlog[f+1], 8'h11);
      chk("t1_valid1", vlog[f+2], 1); chk("t1_data1", dlog[f+2], 8'h22);
      chk("t1_valid2", vlog[f+3], 1); chk("t1_data2", dlog[f+3], 8'h33);
    end
    chk("t1_rd_count", rd_count, 3);
    chk("t1_xsum", xsum, 8'h00);
    idle_cycles(3);

    // Bursts of 4 separated by gap 3
    push_words(10);
    en = 1'b1; burst_len = 4; gap_len = 3; m_ready = 1'b1;
    rinc_log.delete();
    repeat (40) cyc();
    check_runs("t2", 10, 4, 3);
    idle_cycles(3);

    // Backpressure: buffer fills at two words
    push_words(5);
    en = 1'b1; burst_len = 0; gap_len = 0; m_ready = 1'b0;
    b = npop;
    vlog.delete(); dlog.delete(); rinc_log.delete();
    repeat (10) cyc();
    chk("t3_pops_blocked", npop - b, 2);
    chk("t3_rinc_blocked", rinc_log[$], 0);
    chk("t3_head_frozen", m_data, dlog[2]);
    bad = 0;
    for (int i = 2; i < dlog.size(); i++) if (!vlog[i] || dlog[i] !== dlog[2]) bad++;
    chk("t3_hold_stable", bad, 0);
    m_ready = 1'b1;
    b = nhs;
    for (int i = 0; i < 40 && nhs - b < 5; i++) cyc();
    chk("t3_all_delivered", nhs - b, 5);
    chk("t3_no_extra", expq.size(), 0);
    idle_cycles(3);

    // Enable dropped mid-burst, then a fresh burst with gap 0
    push_words(6);
    en = 1'b1; burst_len = 8; gap_len = 2; m_ready = 1'b1;
    run_pops("t4_two_pops", 2, 20);
    en = 1'b0;
    rinc_log.delete();
    cyc();
    chk("t4_rinc_gated_same_cycle", rinc_log[0], 0);
    chk("t4_fifo_nonempty", fq.size(), 4);
    repeat (4) cyc();
    chk("t4_no_pops_disabled", npop - b >= 0 && fq.size() == 4, 1);
    chk("t4_buffer_drained", m_valid, 0);
    chk("t4_busy_idle", busy, 0);
    en = 1'b1; burst_len = 3; gap_len = 0;
    rinc_log.delete();
    repeat (10) cyc();
    check_runs("t4b", 4, 3, 0);
    idle_cycles(3);

    // Reset with a full buffer mid-burst
    push_words(5);
    en = 1'b1; burst_len = 0; gap_len = 0; m_ready = 1'b0;
    run_pops("t5_fill", 2, 20);
    chk("t5_full", m_valid, 1);
    en = 1'b0; rrst = 1'b1;
    cyc();
    rrst = 1'b0;
    chk("t5_m_valid", m_valid, 0);
    chk("t5_m_data", m_data, 0);
    chk("t5_rd_count", rd_count, 0);
    chk("t5_xsum", xsum, 0);
    chk("t5_busy", busy, 0);
    chk("t5_rinc", rinc, 0);
    fq.delete();
    idle_cycles(2);

    // Counter wrap on a 4-bit rd_count
    push_words(17);
    en = 1'b1; burst_len = 0; gap_len = 0; m_ready = 1'b1;
    run_pops("t6_pops", 17, 60);
    chk("t6_wrap", rd_count, 17 % (1 << CNT_W));
    idle_cycles(3);

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0 && fq.size() < 12) push_words($urandom_range(1, 3));
      m_ready = ($urandom_range(0, 3) != 0);
      en      = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 19) == 0) begin
        burst_len = BLEN_W'($urandom_range(0, 6));
        gap_len   = GAP_W'($urandom_range(0, 3));
      end
      cyc();
    end
    en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 300 && (fq.size() != 0 || expq.size() != 0); i++) cyc();
    chk("t7_drained", fq.size() + expq.size(), 0);
    chk("t7_rd_count", rd_count, cnt % (1 << CNT_W));
    chk("t7_xsum", xsum, xs);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
